seq_addsub: RTL and testbench
=============================

SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2, bits processed per clock; SHALL divide WIDTH exactly; N = WIDTH/DIGIT is the iteration count.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; a, b, cin, s_op are captured on the edge at which start is accepted.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in for add, borrow-in for subtract.
REQ-009 s_op  input  1  0 = add, 1 = subtract.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; s and cout are valid while done is high.
REQ-012 s  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry-out.
REQ-014 ovf  output  1  signed overflow; present only when the macro in REQ-032 is defined.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-016 Add: {cout,s} SHALL equal a + b + cin, taken modulo 2^(WIDTH+1).
REQ-017 Subtract: {cout,s} SHALL equal a + ~b + ~cin, i.e. s = a - b - cin mod 2^WIDTH; cout = 1 means no borrow.
REQ-018 start SHALL be accepted only in IDLE or DONE; that edge loads the operand/carry working registers, clears the iteration counter, and moves the FSM to RUN.
REQ-019 In RUN, each edge SHALL add one DIGIT-bit slice, LSB slice first, and propagate the carry to the next slice.
REQ-020 The edge that processes slice N-1 SHALL write s and cout (and ovf) and move the FSM to DONE.
REQ-021 Latency: if start is accepted at edge k, done SHALL be high for exactly the cycle between edges k+N and k+N+1.
REQ-022 busy SHALL be high exactly while the FSM is in RUN, i.e. from edge k to edge k+N.
REQ-023 From DONE the FSM SHALL return to IDLE unless start is high, in which case it SHALL go to RUN (back-to-back operation, no idle cycle).
REQ-024 start while in RUN SHALL be ignored, and the in-flight operation SHALL NOT be disturbed.
REQ-025 Changes on a, b, cin or s_op after acceptance SHALL NOT affect the in-flight result.
REQ-026 s, cout and ovf SHALL hold their last result until the next completion or reset; they SHALL NOT show partial sums.
REQ-027 When DIGIT = WIDTH (N = 1), the result SHALL appear on the first RUN edge, and done SHALL follow start acceptance by one cycle.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE with busy = 0, done = 0, s = 0, cout = 0, ovf = 0, and the counter and working registers cleared.
REQ-029 Reset asserted mid-operation SHALL abort the operation immediately (asynchronously); no done pulse SHALL follow for the aborted operation.
REQ-030 start SHALL NOT be accepted on any edge at which rst is high.
REQ-031 The first acceptance possible after reset is on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro SEQ_ADDSUB_OVF_EN, when defined, SHALL compile in port ovf: the XOR of the carry into the MSB and the carry out of the MSB of the effective addition, registered together with s.
REQ-033 Without SEQ_ADDSUB_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, DIGIT=2, N=4)
REQ-034 a=0x03, b=0x01, cin=0, s_op=0, start pulse -> done exactly 4 edges after acceptance, s=0x04, cout=0; busy high for 4 cycles.
REQ-035 a=0x03, b=0x01, s_op=1, cin=0 -> s=0x02, cout=1; a=0x00, b=0x01, s_op=1 -> s=0xFF, cout=0.
REQ-036 a=0xFF, b=0x01, add -> s=0x00, cout=1, ovf=0; a=0x7F, b=0x01, add -> s=0x80, ovf=1 (with macro); a=0x80, b=0x01, subtract -> s=0x7F, ovf=1.
REQ-037 Second start asserted during RUN with different operands -> ignored, first result unchanged; start held high in the DONE cycle -> second operation runs back-to-back, next done 4 edges later.
REQ-038 rst pulsed 2 cycles after acceptance -> busy, done, s and cout fall to 0 at once, no done pulse; a new start after release completes normally.
REQ-039 Rebuild with DIGIT=8 and with DIGIT=1 and repeat REQ-034..036 -> identical results, with latency 1 and 8 cycles respectively.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that processes DIGIT bits per clock,
// LSB slice first, taking N = WIDTH/DIGIT cycles per operation.
//
// Parameters: WIDTH (>= 2) operand width; DIGIT bits per clock (must divide WIDTH).
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request; a, b, cin, s_op captured when accepted (IDLE or DONE)
//   a, b  - operands
//   cin   - carry-in (add) / borrow-in (subtract)
//   s_op  - 0 = add, 1 = subtract
//   busy  - high while the operation is running
//   done  - one-cycle pulse, s/cout valid
//   s     - registered result
//   cout  - registered carry-out (subtract: 1 = no borrow)
//   ovf   - signed overflow, only when SEQ_ADDSUB_OVF_EN is defined
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             s_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SEQ_ADDSUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;     // holds the effective (possibly inverted) B operand
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   slice;
    logic             accept;
    logic             last;

    // Slice adder; the completed slice is shifted in from the top of the accumulator
    always_comb begin
        slice   = {1'b0, areg[DIGIT-1:0]} + {1'b0, breg[DIGIT-1:0]} + (DIGIT+1)'(carry);
        acc_nxt = WIDTH'({slice[DIGIT-1:0], acc} >> DIGIT);
        accept  = start && (state != RUN);
        last    = (cnt == CW'(N - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Datapath: operands shift right one slice per RUN cycle; s written only at the end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg  <= '0;
            breg  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SEQ_ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            // Subtract is a + ~b + ~cin
            areg  <= a;
            breg  <= s_op ? ~b : b;
            carry <= s_op ? ~cin : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            areg  <= areg >> DIGIT;
            breg  <= breg >> DIGIT;
            acc   <= acc_nxt;
            carry <= slice[DIGIT];
            cnt   <= cnt + CW'(1);
            if (last) begin
                s    <= acc_nxt;
                cout <= slice[DIGIT];
`ifdef SEQ_ADDSUB_OVF_EN
                // Carry into MSB recovered as a^b^s at the MSB
                ovf  <= areg[DIGIT-1] ^ breg[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub (WIDTH=8, DIGIT overridable). Stimulus pushes
// expected results on acceptance; a monitor pops and compares on each done.
module tb_seq_addsub;

    parameter int DIGIT = 2;
    localparam int WIDTH = 8;
    localparam int N = WIDTH / DIGIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b, s;
    logic       cin, s_op, busy, done, cout;
`ifdef SEQ_ADDSUB_OVF_EN
    logic       ovf;
`endif

    seq_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s_op  (s_op),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef SEQ_ADDSUB_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       op;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        int         due;
        int         id;
    } exp_t;

    vec_t vecs[10];
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a vector with start high; returns #1 after the accepting edge
    task automatic issue(input int id);
        a     = vecs[id].a;
        b     = vecs[id].b;
        cin   = vecs[id].cin;
        s_op  = vecs[id].op;
        start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{vecs[id].s, vecs[id].cout, vecs[id].ovf, cyc + N, id});
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        s_op  = 1'($urandom);
    endtask

    task automatic run_single(input int id);
        int nb;
        issue(id);
        nb = int'(busy);
        repeat (N) begin
            @(posedge clk);
            #1;
            nb += int'(busy);
        end
        chk($sformatf("vec%0d_busy_len", id), 32'(nb), 32'(N));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //          a      b      cin   op    s      cout  ovf
        vecs[0] = '{8'h03, 8'h01, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h01, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
        vecs[7] = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0};
        vecs[8] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        s_op  = 1'b0;

        fork
            begin : stimulus
                int w;
                repeat (2) @(posedge clk);
                #1;
                chk("reset_busy", 32'(busy), 32'(0));
                chk("reset_done", 32'(done), 32'(0));
                chk("reset_s",    32'(s),    32'(0));
                chk("reset_cout", 32'(cout), 32'(0));
`ifdef SEQ_ADDSUB_OVF_EN
                chk("reset_ovf",  32'(ovf),  32'(0));
`endif
                rst = 1'b0;

                for (int i = 0; i < 10; i++) run_single(i);

                // start held through RUN with other operands is ignored
                issue(0);
                a     = 8'hAA;
                b     = 8'h55;
                s_op  = 1'b1;
                cin   = 1'b1;
                start = 1'b1;
                repeat (N) begin
                    @(posedge clk);
                    #1;
                end
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1;

                // back-to-back: second start presented in the DONE cycle
                issue(1);
                repeat (N) begin
                    @(posedge clk);
                    #1;
                end
                issue(2);
                repeat (N + 2) @(posedge clk);
                #1;

                // reset two cycles into an operation aborts it
                issue(3);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                rst = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 32'(0));
                chk("abort_done", 32'(done), 32'(0));
                chk("abort_s",    32'(s),    32'(0));
                chk("abort_cout", 32'(cout), 32'(0));
`ifdef SEQ_ADDSUB_OVF_EN
                chk("abort_ovf",  32'(ovf),  32'(0));
`endif
                void'(q.pop_back());
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                run_single(4);
                repeat (N + 2) @(posedge clk);

                w = 0;
                while (q.size() != 0 && w < 50) begin
                    @(posedge clk);
                    w++;
                end
                chk("scoreboard_drain", 32'(q.size()), 32'(0));
                stim_done = 1'b1;
            end
            begin : monitor
                exp_t e;
                while (!stim_done) begin
                    @(negedge clk);
                    if (!rst && done) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("vec%0d_s", e.id),       32'(s),    32'(e.s));
                            chk($sformatf("vec%0d_cout", e.id),    32'(cout), 32'(e.cout));
`ifdef SEQ_ADDSUB_OVF_EN
                            chk($sformatf("vec%0d_ovf", e.id),     32'(ovf),  32'(e.ovf));
`endif
                            chk($sformatf("vec%0d_latency", e.id), 32'(cyc), 32'(e.due));
                        end
                    end
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
